// File: rtl/ten_eth_pkg.sv
// Shared definitions for the 10G transmit port: header offsets, frame limits,
// the metadata record carried between ingress and egress, and the egress states.
package ten_eth_pkg;

  // Largest frame accepted by default, in 64-bit beats (1518 B plus margin).
  localparam int MAX_BEATS_DEF = 190;

  // Source MAC placement with byte0 at [63:56]:
  // bytes 6..7 of beat0 hold MAC[47:32], bytes 0..3 of beat1 hold MAC[31:0].
  localparam int SRC_HI_LSB = 0;
  localparam int SRC_LO_LSB = 32;

  localparam int META_W = 25;

  // One record per frame, written when the frame's last beat is accepted.
  typedef struct packed {
    logic        bad;
    logic [15:0] len;
    logic [7:0]  keep;
  } meta_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DROP = 2'd3
  } eg_state_t;

  // Debug view: egress state plus the port index this instance serves.
  typedef struct packed {
    eg_state_t  state;
    logic [7:0] port_id;
  } dbg_t;

  // Replace the source MAC bytes that fall in beat 0 or beat 1.
  function automatic logic [63:0] src_rewrite(input logic [63:0] beat,
                                              input logic [15:0] idx,
                                              input logic [47:0] mac);
    logic [63:0] r;
    r = beat;
    if (idx == 16'd0) begin
      r[SRC_HI_LSB +: 16] = mac[47:32];
    end else if (idx == 16'd1) begin
      r[SRC_LO_LSB +: 32] = mac[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ten_eth_tx_fifo.sv
// First-word-fall-through synchronous FIFO with a free-entry count.
// The head entry is visible on rd_data whenever empty is low; rd_en pops it.
module tx_sync_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  count;
  logic         full;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign free    = (AW+1)'(DEPTH) - count;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array; written only when there is room.
  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Read/write pointers with an extra wrap bit so full and empty differ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ten_eth_tx.sv
// Transmit side of one 10G port: store-and-forward buffering from the crossbar,
// optional source MAC rewrite, and drop of oversize or link-down frames.
//
// Handshake rule on both AXIS sides: a beat transfers on a clock edge where
// tvalid and tready are both high; the sender holds tvalid, tdata, tlast and
// tkeep stable until that edge, and tready may change freely.
module ten_eth_tx
  import ten_eth_pkg::*;
#(
  parameter int          P_TX_PORT_ID  = 0,
  parameter logic [47:0] P_MY_PORT_MAC = 48'h8DBC5C4A0001,
  parameter bit          P_SRC_REWRITE = 1'b1,
  parameter int          P_DEPTH       = 256,
  parameter int          P_MAX_BEATS   = MAX_BEATS_DEF,
  parameter int          P_META_DEPTH  = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stat_tx_status,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic [7:0]  s_axis_tkeep,
  output logic        m_axis_tx_tvalid,
  input  logic        m_axis_tx_tready,
  output logic [63:0] m_axis_tx_tdata,
  output logic        m_axis_tx_tlast,
  output logic [7:0]  m_axis_tx_tkeep,
  output logic        m_axis_tx_tuser,
  output logic [31:0] o_tx_frame_cnt,
  output logic [15:0] o_drop_cnt,
  output logic        o_drop_pulse,
  output dbg_t        o_dbg
);

  localparam int DAW = $clog2(P_DEPTH);
  localparam int MAW = $clog2(P_META_DEPTH);

  // FIFO interfaces
  logic [DAW:0] d_free;
  logic         d_wr, d_rd, d_empty;
  logic [63:0]  d_head;
  logic [MAW:0] m_free;
  logic         m_wr, m_rd, m_empty;
  meta_t        m_head;
  meta_t        meta_q;

  // Ingress state
  logic        ready_en, in_frame, in_bad, meta_pend;
  logic [15:0] beat_cnt, stored_cnt;
  logic        acc, can_start, cur_bad, over, frame_bad;
  logic [15:0] cnt_now, stor_now, stored_nxt;

  // Egress state
  eg_state_t   state, state_nxt;
  logic [15:0] len_r, idx_r;
  logic [7:0]  keep_r;
  logic        out_valid, out_last;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic        load_first, load_next, send_done, drop_done;
  logic [15:0] cur_idx, cur_len;
  logic        is_last;
  logic [7:0]  keep_nxt;
  logic [63:0] beat_nxt;

  tx_sync_fifo #(.W(64), .DEPTH(P_DEPTH)) u_data_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (d_wr),
    .wr_data (s_axis_tdata),
    .rd_en   (d_rd),
    .rd_data (d_head),
    .empty   (d_empty),
    .free    (d_free)
  );

  tx_sync_fifo #(.W(META_W), .DEPTH(P_META_DEPTH)) u_meta_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (m_wr),
    .wr_data (meta_q),
    .rd_en   (m_rd),
    .rd_data (m_head),
    .empty   (m_empty),
    .free    (m_free)
  );

  // Ingress admission and write decisions. A frame starts only with room for a
  // maximum-size frame and a meta slot not already claimed by a pending record.
  always_comb begin
    can_start     = (int'(d_free) >= P_MAX_BEATS) && (m_free > (MAW+1)'(meta_pend));
    s_axis_tready = ready_en && (in_frame || can_start);
    acc           = s_axis_tvalid && s_axis_tready;
    cur_bad       = in_frame ? in_bad : !i_stat_tx_status;
    cnt_now       = in_frame ? beat_cnt : 16'd0;
    stor_now      = in_frame ? stored_cnt : 16'd0;
    over          = (int'(cnt_now) >= P_MAX_BEATS);
    frame_bad     = cur_bad || over;
    d_wr          = acc && !frame_bad;
    stored_nxt    = stor_now + 16'(d_wr);
  end

  assign m_wr = meta_pend;

  // Ingress frame tracking; the meta record is pushed one cycle after tlast.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_en   <= 1'b0;
      in_frame   <= 1'b0;
      in_bad     <= 1'b0;
      beat_cnt   <= 16'd0;
      stored_cnt <= 16'd0;
      meta_pend  <= 1'b0;
      meta_q     <= '0;
    end else begin
      ready_en  <= 1'b1;
      meta_pend <= acc && s_axis_tlast;
      if (acc) begin
        if (s_axis_tlast) begin
          in_frame    <= 1'b0;
          in_bad      <= 1'b0;
          beat_cnt    <= 16'd0;
          stored_cnt  <= 16'd0;
          meta_q.bad  <= frame_bad;
          meta_q.len  <= stored_nxt;
          meta_q.keep <= s_axis_tkeep;
        end else begin
          in_frame   <= 1'b1;
          in_bad     <= frame_bad;
          beat_cnt   <= (cnt_now == 16'hFFFF) ? cnt_now : cnt_now + 16'd1;
          stored_cnt <= stored_nxt;
        end
      end
    end
  end

  // Egress state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Egress next state and FIFO pops.
  always_comb begin
    state_nxt  = state;
    m_rd       = 1'b0;
    d_rd       = 1'b0;
    load_first = 1'b0;
    load_next  = 1'b0;
    send_done  = 1'b0;
    drop_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!m_empty) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        m_rd = 1'b1;
        if (m_head.bad) begin
          state_nxt = ST_DROP;
        end else begin
          state_nxt  = ST_SEND;
          d_rd       = 1'b1;
          load_first = 1'b1;
        end
      end
      ST_SEND: begin
        if (out_valid && m_axis_tx_tready) begin
          if (out_last) begin
            send_done = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            d_rd      = 1'b1;
            load_next = 1'b1;
          end
        end
      end
      ST_DROP: begin
        d_rd = (idx_r < len_r);
        if (({1'b0, idx_r} + 17'd1) >= {1'b0, len_r}) begin
          drop_done = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next output beat: head of the data FIFO, rewritten, with last/keep flags.
  always_comb begin
    cur_idx  = load_first ? 16'd0 : idx_r;
    cur_len  = load_first ? m_head.len : len_r;
    is_last  = (({1'b0, cur_idx} + 17'd1) == {1'b0, cur_len});
    keep_nxt = is_last ? (load_first ? m_head.keep : keep_r) : 8'hFF;
    beat_nxt = P_SRC_REWRITE ? src_rewrite(d_head, cur_idx, P_MY_PORT_MAC) : d_head;
  end

  // Egress output register and beat index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_r     <= 16'd0;
      keep_r    <= 8'd0;
      idx_r     <= 16'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 64'd0;
      out_keep  <= 8'd0;
    end else begin
      if (state == ST_LOAD) begin
        len_r  <= m_head.len;
        keep_r <= m_head.keep;
      end
      if (load_first || load_next) begin
        out_valid <= 1'b1;
        out_data  <= beat_nxt;
        out_last  <= is_last;
        out_keep  <= keep_nxt;
        idx_r     <= cur_idx + 16'd1;
      end else if (send_done) begin
        out_valid <= 1'b0;
        out_data  <= 64'd0;
        out_last  <= 1'b0;
        out_keep  <= 8'd0;
      end else if (state == ST_LOAD) begin
        idx_r <= 16'd0;
      end else if (state == ST_DROP && d_rd) begin
        idx_r <= idx_r + 16'd1;
      end
    end
  end

  // Frame and drop statistics.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tx_frame_cnt <= 32'd0;
      o_drop_cnt     <= 16'd0;
      o_drop_pulse   <= 1'b0;
    end else begin
      o_drop_pulse <= drop_done;
      if (send_done) o_tx_frame_cnt <= o_tx_frame_cnt + 32'd1;
      if (drop_done && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

  assign m_axis_tx_tvalid = out_valid;
  assign m_axis_tx_tdata  = out_data;
  assign m_axis_tx_tlast  = out_last;
  assign m_axis_tx_tkeep  = out_keep;
  assign m_axis_tx_tuser  = 1'b0;
  assign o_dbg.state      = state;
  assign o_dbg.port_id    = 8'(P_TX_PORT_ID);

endmodule

// File: tb/tb_ten_eth_tx.sv
// Bench for ten_eth_tx: per-scenario tasks, a scoreboard queue fed by the
// frame driver and drained by the MAC-side monitor, and one summary line.
module tb_ten_eth_tx;
  import ten_eth_pkg::*;

  localparam logic [47:0] MY_MAC = 48'h8DBC5C4A0001;
  localparam int          MAXB   = 190;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        link = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = 64'd0;
  logic        s_last = 1'b0;
  logic [7:0]  s_keep = 8'd0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic        m_last;
  logic [7:0]  m_keep;
  logic        m_user;
  logic [31:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        drop_pulse;
  dbg_t        dbg;

  int errors = 0;
  int checks = 0;
  logic [72:0] exp_q[$];
  int cyc = 0;
  int last_edge = 0;
  int first_valid_cyc = -1;
  bit watch_first = 1'b0;
  int pulse_cnt = 0;
  int valid_cycles = 0;
  int mon_beats = 0;
  int exp_frames = 0;
  int exp_drops = 0;
  logic [72:0] prev_beat = '0;
  bit prev_hold = 1'b0;

  ten_eth_tx dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_stat_tx_status (link),
    .s_axis_tvalid    (s_valid),
    .s_axis_tready    (s_ready),
    .s_axis_tdata     (s_data),
    .s_axis_tlast     (s_last),
    .s_axis_tkeep     (s_keep),
    .m_axis_tx_tvalid (m_valid),
    .m_axis_tx_tready (m_ready),
    .m_axis_tx_tdata  (m_data),
    .m_axis_tx_tlast  (m_last),
    .m_axis_tx_tkeep  (m_keep),
    .m_axis_tx_tuser  (m_user),
    .o_tx_frame_cnt   (frame_cnt),
    .o_drop_cnt       (drop_cnt),
    .o_drop_pulse     (drop_pulse),
    .o_dbg            (dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor on the MAC side, sampled on the falling edge.
  always @(negedge clk) begin
    logic [72:0] got;
    logic [72:0] exp;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      got = {m_last, m_keep, m_data};
      if (m_valid) valid_cycles++;
      if (drop_pulse) pulse_cnt++;
      if (watch_first && m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_hold) begin
        checks++;
        if (!m_valid || got !== prev_beat) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %h required v=1 %h", m_valid, got, prev_beat);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        mon_beats++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h required no beat", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp || m_user !== 1'b0) begin
            errors++;
            $display("FAIL out_beat: got %h user=%0b required %h user=0", got, m_user, exp);
          end
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_beat = got;
    end
  end

  // Drive one frame on the crossbar side; push expected MAC beats when it should pass.
  task automatic send_frame(input int n, input logic [7:0] lkeep, input logic [47:0] dst,
                            input logic [47:0] src, input bit expect_out, output bit start_stall);
    logic [63:0] d;
    logic [63:0] e;
    logic        lb;
    int          wait_c;
    start_stall = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      if (i == 0) d = {dst, src[47:32]};
      else if (i == 1) d[63:32] = src[31:0];
      e = d;
      if (i == 0) e[15:0] = MY_MAC[47:32];
      else if (i == 1) e[63:32] = MY_MAC[31:0];
      lb = (i == n - 1);
      if (expect_out) exp_q.push_back({lb, lb ? lkeep : 8'hFF, e});
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = lb;
      s_keep  = lb ? lkeep : 8'hFF;
      wait_c  = 0;
      @(negedge clk);
      while (!s_ready) begin
        if (i == 0) start_stall = 1'b1;
        wait_c++;
        if (wait_c > 4000) begin
          checks++;
          errors++;
          $display("FAIL ingress_timeout: beat %0d not accepted within 4000 cycles", i);
          s_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      if (lb) last_edge = cyc + 1;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Wait until every expected beat has left and egress is idle, then settle.
  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 || dbg.state != ST_IDLE || m_valid) begin
      @(negedge clk);
      w++;
      if (w > 6000) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
        exp_q.delete();
        return;
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_user !== 1'b0 || drop_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got sr=%0b mv=%0b mu=%0b dp=%0b required 0 0 0 0",
               s_ready, m_valid, m_user, drop_pulse);
    end
    checks++;
    if (m_data !== 64'd0 || m_last !== 1'b0 || m_keep !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h %0b %h required 0 0 00", m_data, m_last, m_keep);
    end
    checks++;
    if (frame_cnt !== 32'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d %0d required 0 0", frame_cnt, drop_cnt);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_clock: got %0b required 0", s_ready);
    end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_clock: got %0b required 1", s_ready);
    end
  endtask

  task automatic test_basic();
    bit st;
    m_ready = 1'b1;
    first_valid_cyc = -1;
    watch_first = 1'b1;
    send_frame(8, 8'hF0, 48'h8DBC5C4A0301, 48'h112233445566, 1'b1, st);
    exp_frames++;
    wait_drain();
    watch_first = 1'b0;
    checks++;
    if (first_valid_cyc != last_edge + 3) begin
      errors++;
      $display("FAIL latency: got edge %0d required edge %0d", first_valid_cyc, last_edge + 3);
    end
    checks++;
    if (frame_cnt !== 32'(exp_frames)) begin
      errors++;
      $display("FAIL basic_frame_cnt: got %0d required %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_stall();
    bit st;
    bit done;
    done = 1'b0;
    fork
      begin
        send_frame(8, 8'hF0, 48'h8DBC5C4A0301, 48'h112233445566, 1'b1, st);
        done = 1'b1;
      end
      begin
        for (int k = 0; k < 2000; k++) begin
          @(posedge clk); #1;
          m_ready = (k % 3 == 0);
          if (done && exp_q.size() == 0) break;
        end
      end
    join
    m_ready = 1'b1;
    exp_frames++;
    wait_drain();
    checks++;
    if (frame_cnt !== 32'(exp_frames)) begin
      errors++;
      $display("FAIL stall_frame_cnt: got %0d required %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_link_down();
    bit st;
    bit any_stall;
    int p0;
    int v0;
    any_stall = 1'b0;
    p0 = pulse_cnt;
    v0 = valid_cycles;
    @(posedge clk); #1;
    link = 1'b0;
    for (int f = 0; f < 3; f++) begin
      send_frame(4 + f, 8'hFC, 48'h8DBC5C4A0302, 48'hA1A2A3A4A5A6, 1'b0, st);
      any_stall = any_stall | st;
      exp_drops++;
    end
    wait_drain();
    link = 1'b1;
    checks++;
    if (any_stall) begin
      errors++;
      $display("FAIL linkdown_ready: got tready low at a frame start required high");
    end
    checks++;
    if (valid_cycles != v0) begin
      errors++;
      $display("FAIL linkdown_tvalid: got %0d valid cycles required 0", valid_cycles - v0);
    end
    checks++;
    if (drop_cnt !== 16'(exp_drops)) begin
      errors++;
      $display("FAIL linkdown_drop_cnt: got %0d required %0d", drop_cnt, exp_drops);
    end
    checks++;
    if (pulse_cnt - p0 != 3) begin
      errors++;
      $display("FAIL linkdown_pulses: got %0d required 3", pulse_cnt - p0);
    end
  endtask

  task automatic test_oversize();
    bit st;
    int p0;
    p0 = pulse_cnt;
    m_ready = 1'b1;
    send_frame(250, 8'hFF, 48'h8DBC5C4A0303, 48'h0A0B0C0D0E0F, 1'b0, st);
    exp_drops++;
    send_frame(10, 8'hC0, 48'h8DBC5C4A0304, 48'h102030405060, 1'b1, st);
    exp_frames++;
    wait_drain();
    checks++;
    if (drop_cnt !== 16'(exp_drops)) begin
      errors++;
      $display("FAIL oversize_drop_cnt: got %0d required %0d", drop_cnt, exp_drops);
    end
    checks++;
    if (pulse_cnt - p0 != 1) begin
      errors++;
      $display("FAIL oversize_pulses: got %0d required 1", pulse_cnt - p0);
    end
    checks++;
    if (frame_cnt !== 32'(exp_frames)) begin
      errors++;
      $display("FAIL oversize_frame_cnt: got %0d required %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_back_to_back();
    bit st0, st1, st2, st3;
    m_ready = 1'b0;
    fork
      begin
        send_frame(100, 8'h80, 48'h8DBC5C4A0311, 48'h111111111111, 1'b1, st0);
        send_frame(100, 8'hE0, 48'h8DBC5C4A0312, 48'h222222222222, 1'b1, st1);
        send_frame(100, 8'hFE, 48'h8DBC5C4A0313, 48'h333333333333, 1'b1, st2);
        send_frame(100, 8'hF8, 48'h8DBC5C4A0314, 48'h444444444444, 1'b1, st3);
      end
      begin
        repeat (400) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    exp_frames += 4;
    wait_drain();
    checks++;
    if (st0 !== 1'b0) begin
      errors++;
      $display("FAIL bp_first_admit: got stalled=%0b required 0", st0);
    end
    checks++;
    if (st1 !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_held: got stalled=%0b required 1", st1);
    end
    checks++;
    if (frame_cnt !== 32'(exp_frames)) begin
      errors++;
      $display("FAIL bp_frame_cnt: got %0d required %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_reset_mid_send();
    bit st;
    int base;
    int w;
    int v0;
    m_ready = 1'b1;
    send_frame(8, 8'hF0, 48'h8DBC5C4A0305, 48'h665544332211, 1'b1, st);
    base = mon_beats;
    w = 0;
    while (mon_beats < base + 3 && w < 200) begin
      @(posedge clk); #2;
      w++;
    end
    checks++;
    if (mon_beats < base + 3) begin
      errors++;
      $display("FAIL mid_send_reach: got %0d beats required 3", mon_beats - base);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 64'd0 || m_last !== 1'b0 || m_keep !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_out: got v=%0b %h %0b %h required all 0", m_valid, m_data, m_last, m_keep);
    end
    checks++;
    if (frame_cnt !== 32'd0 || drop_cnt !== 16'd0 || drop_pulse !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_cnt: got %0d %0d %0b %0b required 0 0 0 0",
               frame_cnt, drop_cnt, drop_pulse, s_ready);
    end
    exp_q.delete();
    exp_frames = 0;
    exp_drops  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v0 = valid_cycles;
    repeat (10) @(negedge clk);
    checks++;
    if (valid_cycles != v0) begin
      errors++;
      $display("FAIL mid_reset_fifo_empty: got %0d valid cycles required 0", valid_cycles - v0);
    end
    send_frame(5, 8'hFE, 48'h8DBC5C4A0306, 48'h0F0E0D0C0B0A, 1'b1, st);
    exp_frames++;
    wait_drain();
    checks++;
    if (frame_cnt !== 32'(exp_frames)) begin
      errors++;
      $display("FAIL mid_reset_frame_cnt: got %0d required %0d", frame_cnt, exp_frames);
    end
  endtask

  // Run scenarios and report.
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_link_down();
    test_oversize();
    test_back_to_back();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
